// File: rtl/or1k_pic_pkg.sv
// Shared constants for the OR1K vectored PIC: SPR offsets, PICID layout, line limit.
package or1k_pic_pkg;
  localparam int MAX_IRQ = 32;

  localparam logic [10:0] PIC_MR_OFS = 11'd0;
  localparam logic [10:0] PIC_SR_OFS = 11'd2;
  localparam logic [10:0] PIC_ER_OFS = 11'd3;
  localparam logic [10:0] PIC_ID_OFS = 11'd4;

  localparam int PICID_IS_BIT = 31;
  localparam int PICID_ID_LSB = 0;
  localparam int PICID_ID_W   = 8;
endpackage

// File: rtl/or1k_pic_prio_enc.sv
// Fixed-priority encoder: the lowest set index wins.
module or1k_pic_prio_enc #(
  parameter int NUM_IRQ = 32,
  parameter int ID_W    = 5
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [ID_W-1:0]    id
);
  always_comb begin
    valid = |req;
    id    = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end
endmodule

// File: rtl/or1k_pic_vectored.sv
// OR1K PIC with per-line edge/level mode, NMI lines and an in-service lock.
// Define OR1K_PIC_SYNC_EN to add a 2-flop synchroniser on every irq_i line.
module or1k_pic_vectored
  import or1k_pic_pkg::*;
#(
  parameter int          NUM_IRQ    = 32,
  parameter int          NMI_WIDTH  = 0,
  parameter logic [31:0] EDGE_RESET = 32'h0,
  parameter int          ID_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               irq_req_o,
  output logic [ID_W-1:0]    irq_id_o,
  input  logic               irq_ack_i,
  output logic [NUM_IRQ-1:0] spr_picmr_o,
  output logic [NUM_IRQ-1:0] spr_picsr_o,
  input  logic               spr_access_i,
  input  logic               spr_we_i,
  input  logic [15:0]        spr_addr_i,
  input  logic [31:0]        spr_dat_i,
  output logic               spr_bus_ack,
  output logic [31:0]        spr_dat_o
);
  localparam logic [63:0]        NMI_ALL  = (64'd1 << NMI_WIDTH) - 64'd1;
  localparam logic [NUM_IRQ-1:0] NMI_MASK = NMI_ALL[NUM_IRQ-1:0];
  localparam logic [NUM_IRQ-1:0] ER_RST   = EDGE_RESET[NUM_IRQ-1:0];

  logic [NUM_IRQ-1:0] picmr_reg, picsr_reg, picer_reg, prev_reg;
  logic [NUM_IRQ-1:0] picsr_next, irq_eff, unmasked, eligible, w1c, ack_line;
  logic               req_reg, in_service_reg;
  logic [ID_W-1:0]    id_reg, is_id_reg, win_id;
  logic               win_valid, ack_take;
  logic               wr_mr, wr_sr, wr_er, wr_id;
  logic [10:0]        ofs;

`ifdef OR1K_PIC_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_reg, sync2_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= irq_i;
      sync2_reg <= sync1_reg;
    end
  end
  assign irq_eff = sync2_reg;
`else
  assign irq_eff = irq_i;
`endif

  assign ofs      = spr_addr_i[10:0];
  assign wr_mr    = spr_access_i & spr_we_i & (ofs == PIC_MR_OFS);
  assign wr_sr    = spr_access_i & spr_we_i & (ofs == PIC_SR_OFS);
  assign wr_er    = spr_access_i & spr_we_i & (ofs == PIC_ER_OFS);
  assign wr_id    = spr_access_i & spr_we_i & (ofs == PIC_ID_OFS);
  assign ack_take = req_reg & irq_ack_i;
  assign unmasked = irq_eff & picmr_reg;
  assign w1c      = wr_sr ? spr_dat_i[NUM_IRQ-1:0] : '0;

  // Set beats clear; the ack only clears the acknowledged line when it is edge-mode.
  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_line
    logic set_line, clr_line;
    assign ack_line[gi]   = ack_take && (id_reg == ID_W'(gi));
    assign set_line       = unmasked[gi] & (~picer_reg[gi] | ~prev_reg[gi]);
    assign clr_line       = w1c[gi] | (ack_line[gi] & picer_reg[gi]);
    assign picsr_next[gi] = set_line | (picsr_reg[gi] & ~clr_line);
  end

  assign eligible = picsr_reg & picmr_reg & (in_service_reg ? NMI_MASK : {NUM_IRQ{1'b1}});

  or1k_pic_prio_enc #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_enc (
    .req   (eligible),
    .valid (win_valid),
    .id    (win_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      picmr_reg      <= NMI_MASK;
      picsr_reg      <= '0;
      picer_reg      <= ER_RST;
      prev_reg       <= '0;
      req_reg        <= 1'b0;
      id_reg         <= '0;
      in_service_reg <= 1'b0;
      is_id_reg      <= '0;
    end else begin
      prev_reg  <= unmasked;
      picsr_reg <= picsr_next;
      if (wr_mr) picmr_reg <= spr_dat_i[NUM_IRQ-1:0] | NMI_MASK;
      if (wr_er) picer_reg <= spr_dat_i[NUM_IRQ-1:0];
      if (ack_take) begin
        req_reg        <= 1'b0;
        in_service_reg <= 1'b1;
        is_id_reg      <= id_reg;
      end else begin
        req_reg <= win_valid;
        id_reg  <= win_id;
        if (wr_id) in_service_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    spr_dat_o = '0;
    if (spr_access_i) begin
      case (ofs)
        PIC_MR_OFS: spr_dat_o = 32'(picmr_reg);
        PIC_SR_OFS: spr_dat_o = 32'(picsr_reg);
        PIC_ER_OFS: spr_dat_o = 32'(picer_reg);
        PIC_ID_OFS: begin
          spr_dat_o[PICID_IS_BIT] = in_service_reg;
          spr_dat_o[PICID_ID_LSB +: PICID_ID_W] = PICID_ID_W'(is_id_reg);
        end
        default: spr_dat_o = '0;
      endcase
    end
  end

  assign spr_bus_ack = spr_access_i;
  assign irq_req_o   = req_reg;
  assign irq_id_o    = id_reg;
  assign spr_picmr_o = picmr_reg;
  assign spr_picsr_o = picsr_reg;
endmodule
